// File: rtl/digdug_pkg.sv
// rtl/digdug_pkg.sv - shared types and defaults for the Dig Dug ROM download path
package digdug_pkg;

  // Loader sequencing: wait for download, take bytes, judge image, settle, release core.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } loader_state_t;

  // Full Dig Dug ROM image as delivered by the HPS in one download.
  localparam int DIGDUG_ROM_BYTES = 65536;

  // Settle time the core stays in reset after a good image, in clk_sys cycles.
  localparam int DIGDUG_HOLD_CYC = 1024;

  // Core ROM write address width.
  localparam int DIGDUG_AW = 16;

endpackage

// File: rtl/digdug_rom_loader_if.sv
// rtl/digdug_rom_loader_if.sv - ioctl download bus in, core ROM write port out
interface digdug_rom_loader_if #(
  parameter int AW = 16
) ();

  // HPS side: download window and per-byte strobe.
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;

  // Core side: ROMEN / ROMAD / ROMDT.
  logic          rom_we;
  logic [AW-1:0] rom_ad;
  logic [7:0]    rom_dt;

  // master drives the download and watches the ROM port (hps_io side / bench).
  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  rom_we,
    input  rom_ad,
    input  rom_dt
  );

  // slave is the loader: consumes the download and produces ROM writes.
  modport slave (
    input  ioctl_download,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output rom_we,
    output rom_ad,
    output rom_dt
  );

endinterface

// File: rtl/digdug_rom_loader.sv
// rtl/digdug_rom_loader.sv - sequences ioctl ROM download into the core and gates core reset
module digdug_rom_loader
  import digdug_pkg::*;
#(
  parameter int ROM_BYTES = DIGDUG_ROM_BYTES,
  parameter int HOLD_CYC  = DIGDUG_HOLD_CYC,
  parameter int AW        = DIGDUG_AW
) (
  input  logic                      clk_sys,
  input  logic                      RESET,
  digdug_rom_loader_if.slave        bus,
  output logic                      core_reset,
  output logic                      load_ok,
  output logic                      load_err,
  output logic [7:0]                csum
);

  // Hold timer is sized for HOLD_CYC-1 down to 0; keep at least one bit.
  localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [24:0] ROM_LIMIT  = 25'(ROM_BYTES);
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(ROM_BYTES);
  localparam logic [TW-1:0] HOLD_TOP = TW'(HOLD_CYC - 1);

  loader_state_t state;
  loader_state_t state_next;

  logic [TW-1:0] timer;
  logic [AW:0]   cnt;
  logic          err_oor;

  logic          rom_we_q;
  logic [AW-1:0] rom_ad_q;
  logic [7:0]    rom_dt_q;
  logic [7:0]    csum_q;
  logic          load_ok_q;
  logic          load_err_q;

  logic          strobe;
  logic          take;
  logic          in_range;
  logic          load_entry;
  logic          image_good;
  logic [AW:0]   cnt_base;
  logic [7:0]    csum_base;

  // Byte acceptance and LOAD-entry bookkeeping, derived from current and next state.
  always_comb begin
    strobe     = bus.ioctl_download & bus.ioctl_wr;
    in_range   = (bus.ioctl_addr < ROM_LIMIT);
    load_entry = (state_next == LOAD) && (state != LOAD);
    // A strobe arriving on the entry cycle itself is part of the new image.
    take       = strobe && (state_next == LOAD);
    image_good = (cnt == CNT_FULL) && !err_oor;
    // On the entry cycle the running totals restart from zero before adding this byte.
    cnt_base   = load_entry ? '0 : cnt;
    csum_base  = load_entry ? 8'h00 : csum_q;
  end

  // Next-state logic and the combinational core reset.
  always_comb begin
    state_next = state;
    core_reset = 1'b1;
    case (state)
      IDLE: begin
        if (bus.ioctl_download) state_next = LOAD;
      end
      LOAD: begin
        if (!bus.ioctl_download) state_next = CHECK;
      end
      CHECK: begin
        state_next = image_good ? HOLD : IDLE;
      end
      HOLD: begin
        if (bus.ioctl_download)  state_next = LOAD;
        else if (timer == '0)    state_next = RUN;
      end
      RUN: begin
        if (bus.ioctl_download)  state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
    // Core runs only while settled in RUN; a new download re-asserts reset in the same cycle.
    core_reset = !((state == RUN) && (state_next == RUN));
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Settle timer: loaded while judging the image, counts down through HOLD.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      timer <= '0;
    end else if (state == CHECK) begin
      timer <= HOLD_TOP;
    end else if ((state == HOLD) && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end

  // Byte path: register each accepted byte, pulse the ROM write, keep count/checksum/status.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      rom_we_q   <= 1'b0;
      rom_ad_q   <= '0;
      rom_dt_q   <= 8'h00;
      cnt        <= '0;
      csum_q     <= 8'h00;
      err_oor    <= 1'b0;
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      rom_we_q <= 1'b0;
      if (load_entry) begin
        cnt        <= '0;
        csum_q     <= 8'h00;
        err_oor    <= 1'b0;
        load_ok_q  <= 1'b0;
        load_err_q <= 1'b0;
      end
      if (take) begin
        rom_ad_q <= bus.ioctl_addr[AW-1:0];
        rom_dt_q <= bus.ioctl_dout;
        if (in_range) begin
          rom_we_q <= 1'b1;
          // Saturate so a runaway download can never wrap back onto a valid count.
          if (cnt_base != '1) cnt <= cnt_base + 1'b1;
          else                cnt <= cnt_base;
          csum_q <= csum_base + bus.ioctl_dout;
        end else begin
          err_oor <= 1'b1;
        end
      end
      if (state == CHECK) begin
        load_ok_q  <= image_good;
        load_err_q <= !image_good;
      end
    end
  end

  assign bus.rom_we = rom_we_q;
  assign bus.rom_ad = rom_ad_q;
  assign bus.rom_dt = rom_dt_q;
  assign csum       = csum_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;

endmodule
